// File: rtl/io_responder_pkg.sv
// Shared I/O map constants and the hex-to-seven-segment glyph table for the
// memory-mapped I/O responder.
package io_responder_pkg;

  localparam logic [31:0] IO_START_MEM = 32'hFFFF_FC00;

  localparam logic [31:0] IO_LED_OFF   = 32'h0000_0000;
  localparam logic [31:0] IO_SW_OFF    = 32'h0000_0004;
  localparam logic [31:0] IO_SEG_OFF   = 32'h0000_0008;
  localparam logic [31:0] IO_BTN_OFF   = 32'h0000_000C;
  localparam logic [31:0] IO_TIMER_OFF = 32'h0000_0010;

  // Active-high {g,f,e,d,c,b,a}; the display driver inverts for the board.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/io_responder_if.sv
// Memory-stage I/O port: the memory stage is the master, the responder the slave.
interface io_responder_if;
  logic [31:0] io_addr;
  logic        io_we;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;

  modport master (output io_addr, io_we, io_write_data, input io_read_data);
  modport slave  (input io_addr, io_we, io_write_data, output io_read_data);
endinterface

// File: rtl/io_debounce.sv
// One-bit button conditioner: 2-flop synchronizer, then a stability counter
// that accepts a new level only after DEB_CYCLES consecutive differing samples.
module io_debounce #(
  parameter logic [19:0] DEB_CYCLES = 20'd1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);
  localparam logic [19:0] DEB_LAST = DEB_CYCLES - 20'd1;

  logic        s1_q, s2_q, level_q, level_d;
  logic [19:0] cnt_q, cnt_d;
  logic        accept;

  assign accept = (s2_q != level_q) && (cnt_q == DEB_LAST);

  // Counter sits at zero whenever the sample agrees with the stable level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (accept)              level_d = s2_q;
    else if (s2_q != level_q) cnt_d  = cnt_q + 20'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = accept & s2_q;
endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O target: LED, switch, seven-segment, button-flag and
// millisecond-timer registers plus the multiplexed 8-digit display scan.
module io_responder
  import io_responder_pkg::*;
#(
  parameter logic [31:0] IO_BASE    = IO_START_MEM,
  parameter int          SW_W       = 24,
  parameter int          LED_W      = 24,
  parameter int          BTN_W      = 5,
  parameter logic [19:0] DEB_CYCLES = 20'd1_000_000,
  parameter logic [16:0] TICK_DIV   = 17'd100_000,
  parameter logic [16:0] SCAN_DIV   = 17'd100_000
) (
  input  logic             clk,
  input  logic             rst,
  io_responder_if.slave    bus,
  input  logic [SW_W-1:0]  sw,
  input  logic [BTN_W-1:0] btn,
  output logic [LED_W-1:0] led,
  output logic [7:0]       seg_an,
  output logic [7:0]       seg_out
);
  localparam logic [16:0] TICK_LAST = TICK_DIV - 17'd1;
  localparam logic [16:0] SCAN_LAST = SCAN_DIV - 17'd1;

  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      seg_q, seg_d;
  logic [31:0]      timer_q, timer_d;
  logic [16:0]      pre_q, pre_d;
  logic [16:0]      scan_q, scan_d;
  logic [2:0]       dig_q, dig_d;
  logic [BTN_W-1:0] flag_q, flag_d;
  logic [SW_W-1:0]  sw1_q, sw2_q;
  logic [BTN_W-1:0] lvl, rise;

  // Offsets below IO_BASE wrap to huge values, but in_io keeps them out anyway.
  logic [31:0] off;
  logic        in_io, wr_led, wr_seg, wr_btn, wr_timer;
  logic [31:0] rdata;

  assign off      = bus.io_addr - IO_BASE;
  assign in_io    = bus.io_addr >= IO_BASE;
  assign wr_led   = bus.io_we && in_io && (off[31:2] == IO_LED_OFF[31:2]);
  assign wr_seg   = bus.io_we && in_io && (off[31:2] == IO_SEG_OFF[31:2]);
  assign wr_btn   = bus.io_we && in_io && (off[31:2] == IO_BTN_OFF[31:2]);
  assign wr_timer = bus.io_we && in_io && (off[31:2] == IO_TIMER_OFF[31:2]);

  for (genvar g = 0; g < BTN_W; g++) begin : g_deb
    io_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn[g]),
      .level_o (lvl[g]),
      .rise_o  (rise[g])
    );
  end

  always_comb begin
    led_d   = led_q;
    seg_d   = seg_q;
    timer_d = timer_q;
    pre_d   = pre_q + 17'd1;
    scan_d  = scan_q + 17'd1;
    dig_d   = dig_q;
    if (pre_q == TICK_LAST) begin
      pre_d   = '0;
      timer_d = timer_q + 32'd1;
    end
    // A timer write overrides a coincident tick and restarts the prescaler.
    if (wr_timer) begin
      timer_d = bus.io_write_data;
      pre_d   = '0;
    end
    if (wr_led) led_d = bus.io_write_data[LED_W-1:0];
    if (wr_seg) seg_d = bus.io_write_data;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      dig_d  = dig_q + 3'd1;
    end
    // Clear first, then OR in new presses so a set wins over a W1C.
    flag_d = (flag_q & ~(wr_btn ? bus.io_write_data[BTN_W-1:0] : '0)) | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= '0;
      seg_q   <= '0;
      timer_q <= '0;
      pre_q   <= '0;
      scan_q  <= '0;
      dig_q   <= '0;
      flag_q  <= '0;
      sw1_q   <= '0;
      sw2_q   <= '0;
    end else begin
      led_q   <= led_d;
      seg_q   <= seg_d;
      timer_q <= timer_d;
      pre_q   <= pre_d;
      scan_q  <= scan_d;
      dig_q   <= dig_d;
      flag_q  <= flag_d;
      sw1_q   <= sw;
      sw2_q   <= sw1_q;
    end
  end

  always_comb begin
    rdata = '0;
    if (in_io) begin
      case (off[31:2])
        IO_LED_OFF[31:2]:   rdata = 32'(led_q);
        IO_SW_OFF[31:2]:    rdata = 32'(sw2_q);
        IO_SEG_OFF[31:2]:   rdata = seg_q;
        IO_BTN_OFF[31:2]:   rdata = 32'(flag_q) | (32'(lvl) << 16);
        IO_TIMER_OFF[31:2]: rdata = timer_q;
        default:            rdata = '0;
      endcase
    end
  end

  assign bus.io_read_data = rdata;
  assign led              = led_q;
  assign seg_an           = ~(8'd1 << dig_q);
  assign seg_out          = ~{1'b0, hex7(seg_q[{dig_q, 2'b00} +: 4])};
endmodule

// File: tb/tb_io_responder.sv
// Randomized bench for io_responder with a cycle-level behavioural model,
// plus directed scenarios that pin the model with hand-computed values.
module tb_io_responder;
  localparam logic [31:0] BASE = 32'hFFFF_FC00;
  localparam int DEB = 4, TICK = 5, SCAN = 3;
  localparam logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] sw  = 24'h5A3C0F;
  logic [4:0]  btn = '0;
  logic [23:0] led;
  logic [7:0]  seg_an, seg_out;

  io_responder_if bus();

  io_responder #(.DEB_CYCLES(20'd4), .TICK_DIV(17'd5), .SCAN_DIV(17'd3)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sw(sw), .btn(btn),
    .led(led), .seg_an(seg_an), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [23:0] m_led = '0, m_sw1 = '0, m_sw2 = '0;
  logic [31:0] m_seg = '0, m_tbase = '0;
  logic [4:0]  m_flags = '0, m_level = '0, m_b1 = '0, m_b2 = '0;
  logic [31:0] m_hist [5] = '{default: '0};
  longint      m_tcyc = 0, m_scyc = 0;

  function automatic logic [31:0] m_timer();
    return m_tbase + 32'(m_tcyc / TICK);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] o;
    if (a < BASE) return 32'h0;
    o = (a - BASE) >> 2;
    case (o)
      0: return {8'h0, m_led};
      1: return {8'h0, m_sw2};
      2: return m_seg;
      3: return {11'h0, m_level, 11'h0, m_flags};
      4: return m_timer();
      default: return 32'h0;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_led = '0; m_seg = '0; m_tbase = '0; m_tcyc = 0; m_scyc = 0;
      m_flags = '0; m_level = '0; m_sw1 = '0; m_sw2 = '0; m_b1 = '0; m_b2 = '0;
      for (int i = 0; i < 5; i++) m_hist[i] = '0;
    end else begin
      logic [4:0] rise_m;
      logic [31:0] o;
      logic hit;
      rise_m = '0;
      // A level flips once the last DEB synchronized samples all disagree with it.
      for (int i = 0; i < 5; i++) begin
        m_hist[i] = (m_hist[i] << 1) | 32'(m_b2[i] != m_level[i]);
        if ((m_hist[i] & ((32'd1 << DEB) - 1)) == ((32'd1 << DEB) - 1)) begin
          m_level[i] = m_b2[i];
          m_hist[i]  = '0;
          if (m_b2[i]) rise_m[i] = 1'b1;
        end
      end
      hit = bus.io_we && (bus.io_addr >= BASE);
      o   = (bus.io_addr - BASE) >> 2;
      m_tcyc++;
      m_scyc++;
      if (hit && o == 0) m_led = bus.io_write_data[23:0];
      if (hit && o == 2) m_seg = bus.io_write_data;
      if (hit && o == 3) m_flags = m_flags & ~bus.io_write_data[4:0];
      if (hit && o == 4) begin m_tbase = bus.io_write_data; m_tcyc = 0; end
      m_flags = m_flags | rise_m;
      m_sw2 = m_sw1; m_sw1 = sw;
      m_b2 = m_b1;   m_b1 = btn;
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    #3;
    if (chk_en) begin
      int d;
      logic [3:0] nib;
      d   = int'((m_scyc / SCAN) % 8);
      nib = 4'((m_seg >> (4 * d)) & 32'hF);
      chk("rd", bus.io_read_data, m_read(bus.io_addr));
      chk("led", {8'h0, led}, {8'h0, m_led});
      chk("seg_an", {24'h0, seg_an}, {24'h0, ~(8'h1 << d)});
      chk("seg_out", {24'h0, seg_out}, {24'h0, ~{1'b0, GLY[nib]}});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [31:0] a, input logic we, input logic [31:0] wd);
    @(negedge clk);
    rst = 1'b0; bus.io_addr = a; bus.io_we = we; bus.io_write_data = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(BASE, 1'b0, 32'h0);
  endtask

  task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string nm);
    step(a, 1'b0, 32'h0);
    #4;
    chk(nm, bus.io_read_data, exp);
  endtask

  task automatic chk_disp(input logic [7:0] an, input logic [7:0] so, input string nm);
    idle(1);
    #4;
    chk({nm, "_an"}, {24'h0, seg_an}, {24'h0, an});
    chk({nm, "_out"}, {24'h0, seg_out}, {24'h0, so});
  endtask

  initial begin
    bus.io_addr = '0; bus.io_we = 1'b0; bus.io_write_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #4;
    chk_en = 1;
    chk("rst_an", {24'h0, seg_an}, 32'hFE);
    chk("rst_out", {24'h0, seg_out}, 32'hC0);
    peek(BASE + 32'h00, 32'h0, "rst_led");
    peek(BASE + 32'h08, 32'h0, "rst_seg");
    peek(BASE + 32'h0C, 32'h0, "rst_btn");
    peek(BASE + 32'h10, 32'h0, "rst_timer");
    peek(BASE + 32'h04, 32'h005A3C0F, "sw_sync");

    step(BASE, 1'b1, 32'h00A5_5A5A);
    peek(BASE, 32'h00A5_5A5A, "led_rd");
    chk("led_pin", {8'h0, led}, 32'h00A5_5A5A);
    step(BASE + 32'h14, 1'b1, 32'h1234);
    peek(BASE + 32'h14, 32'h0, "unmapped");
    peek(32'h0000_1000, 32'h0, "below_base");
    peek(BASE + 32'h01, 32'h00A5_5A5A, "led_misaligned");

    @(negedge clk); btn = 5'b00100; bus.io_we = 1'b0;
    idle(1);
    @(negedge clk); btn = 5'b0;
    idle(6);
    peek(BASE + 32'h0C, 32'h0, "btn_glitch");
    @(negedge clk); btn = 5'b00100;
    idle(7);
    peek(BASE + 32'h0C, 32'h0004_0004, "btn_press");
    step(BASE + 32'h0C, 1'b1, 32'h4);
    peek(BASE + 32'h0C, 32'h0004_0000, "btn_w1c");
    @(negedge clk); btn = 5'b0;
    idle(7);
    @(negedge clk); btn = 5'b00100; bus.io_we = 1'b0;
    idle(4);
    step(BASE + 32'h0C, 1'b1, 32'h4);
    peek(BASE + 32'h0C, 32'h0004_0004, "btn_set_wins");

    step(BASE + 32'h10, 1'b1, 32'hFFFF_FFFE);
    idle(5);
    peek(BASE + 32'h10, 32'hFFFF_FFFF, "timer_tick");
    idle(4);
    peek(BASE + 32'h10, 32'h0, "timer_wrap");
    idle(3);
    step(BASE + 32'h10, 1'b1, 32'h10);
    peek(BASE + 32'h10, 32'h10, "timer_wr_tick");
    idle(4);
    peek(BASE + 32'h10, 32'h11, "timer_after");

    @(negedge clk); rst = 1'b1; bus.io_we = 1'b0;
    step(BASE + 32'h08, 1'b1, 32'h0000_00F8);
    chk_disp(8'hFE, 8'h80, "d0");
    idle(1);
    chk_disp(8'hFD, 8'h8E, "d1");
    idle(20);
    chk_disp(8'hFE, 8'h80, "d0_again");

    @(negedge clk); btn = 5'b00001; bus.io_we = 1'b0;
    idle(3);
    @(negedge clk); rst = 1'b1; bus.io_addr = BASE; bus.io_we = 1'b1; bus.io_write_data = 32'hFF_FFFF;
    peek(BASE, 32'h0, "rst_drop_wr");
    chk("rst_led_out", {8'h0, led}, 32'h0);
    peek(BASE + 32'h0C, 32'h0, "rst_deb");
    peek(BASE + 32'h10, 32'h0, "rst_tick");

    for (int c = 0; c < 3000; c++) begin
      logic [31:0] a;
      case ($urandom_range(0, 7))
        5:       a = 32'h0000_1000;
        6:       a = BASE + 32'($urandom_range(0, 1023));
        7:       a = $urandom;
        default: a = BASE + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
      endcase
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      bus.io_addr = a;
      bus.io_we = ($urandom_range(0, 2) == 0);
      bus.io_write_data = $urandom;
      for (int i = 0; i < 5; i++) if ($urandom_range(0, 9) == 0) btn[i] = ~btn[i];
      if ($urandom_range(0, 15) == 0) sw = 24'($urandom);
    end
    @(negedge clk); rst = 1'b0; bus.io_we = 1'b0;
    @(negedge clk);
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
